// File: rtl/aes_simd_pkg.sv
// aes_simd_pkg: shared FSM state type, GF(2^8) helpers and MixColumns coefficients.
package aes_simd_pkg;
  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
  localparam logic [7:0] AES_POLY = 8'h1B;
  // Coefficient rows, leftmost byte multiplies s0 when producing r0.
  localparam logic [31:0] FWD_COEF = 32'h02030101;
  localparam logic [31:0] INV_COEF = 32'h0E0B0D09;
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = xtime(x);
    end
    return p;
  endfunction
endpackage

// File: rtl/aes_mixcol_seq_if.sv
// aes_mixcol_seq_if: control handshake and register-file column port of the sequencer.
interface aes_mixcol_seq_if;
  logic        start;
  logic [1:0]  blk_sel;
  logic        inv;
  logic        busy;
  logic        done;
  logic [3:0]  rf_fila;
  logic [1:0]  rf_columna;
  logic        rf_col_read;
  logic        rf_wr_en;
  logic        rf_col_write;
  logic [31:0] rf_data_wr;
  logic [31:0] rf_data_rd;
  modport master (
    output start, blk_sel, inv, rf_data_rd,
    input  busy, done, rf_fila, rf_columna, rf_col_read, rf_wr_en, rf_col_write, rf_data_wr
  );
  modport slave (
    input  start, blk_sel, inv, rf_data_rd,
    output busy, done, rf_fila, rf_columna, rf_col_read, rf_wr_en, rf_col_write, rf_data_wr
  );
endinterface

// File: rtl/aes_mixcol_col.sv
// aes_mixcol_col: combinational (Inv)MixColumns of one 32-bit column, s0 in the MSB byte.
module aes_mixcol_col
  import aes_simd_pkg::*;
(
  input  logic [31:0] i_col,
  input  logic        i_inv,
  output logic [31:0] o_col
);
  logic [31:0] w_coef;
  assign w_coef = i_inv ? INV_COEF : FWD_COEF;
  // Row r uses the coefficient row rotated right by r bytes.
  always_comb begin
    o_col = '0;
    for (int r = 0; r < 4; r++)
      for (int j = 0; j < 4; j++)
        o_col[31-8*r -: 8] = o_col[31-8*r -: 8] ^ gmul(i_col[31-8*j -: 8], w_coef[31-8*((j-r+4)%4) -: 8]);
  end
endmodule

// File: rtl/aes_mixcol_seq.sv
// aes_mixcol_seq: reads each column of a 4-row state block, mixes it and writes it back,
// alternating read and write cycles over columns 0..3.
module aes_mixcol_seq
  import aes_simd_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  aes_mixcol_seq_if.slave  bus
);
  state_t      r_state;
  logic [1:0]  r_col;
  logic [31:0] r_col_q;
  logic [3:0]  r_base;
  logic        r_inv;
  logic        w_rd;
  logic        w_wr;
  logic [31:0] w_mix;
  aes_mixcol_col u_col (
    .i_col (r_col_q),
    .i_inv (r_inv),
    .o_col (w_mix)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_col   <= '0;
      r_col_q <= '0;
      r_base  <= '0;
      r_inv   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (bus.start) begin
          r_base  <= {bus.blk_sel, 2'b00};
          r_inv   <= bus.inv;
          r_col   <= '0;
          r_state <= RD;
        end
        RD: begin
          r_col_q <= bus.rf_data_rd;
          r_state <= WR;
        end
        WR: begin
          r_col   <= r_col + 2'd1;
          r_state <= (r_col == 2'd3) ? DONE : RD;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  // Every register-file output is decoded from the state register, so all go quiet outside RD/WR.
  assign w_rd             = (r_state == RD);
  assign w_wr             = (r_state == WR);
  assign bus.busy         = w_rd | w_wr;
  assign bus.done         = (r_state == DONE);
  assign bus.rf_fila      = bus.busy ? r_base : 4'd0;
  assign bus.rf_columna   = bus.busy ? r_col : 2'd0;
  assign bus.rf_col_read  = w_rd;
  assign bus.rf_wr_en     = w_wr;
  assign bus.rf_col_write = w_wr;
  assign bus.rf_data_wr   = w_wr ? w_mix : 32'd0;
endmodule

// File: tb/tb_aes_mixcol_seq.sv
// tb_aes_mixcol_seq: directed vectors against a behavioural 16x32 register file.
module tb_aes_mixcol_seq;
  logic clk;
  logic rst_n;
  aes_mixcol_seq_if bus ();
  aes_mixcol_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  logic [31:0] regs [16];
  logic        ld_en;
  logic [3:0]  ld_base;
  logic [1:0]  ld_c;
  logic [31:0] ld_val;
  int n_assert = 0;
  int n_fail = 0;
  always_comb begin
    bus.rf_data_rd = '0;
    for (int k = 0; k < 4; k++)
      bus.rf_data_rd[31-8*k -: 8] = regs[4'(bus.rf_fila + 4'(k))][31-8*bus.rf_columna -: 8];
  end
  always @(posedge clk) begin
    if (ld_en) begin
      for (int k = 0; k < 4; k++)
        regs[4'(ld_base + 4'(k))][31-8*ld_c -: 8] <= ld_val[31-8*k -: 8];
    end else if (bus.rf_wr_en && bus.rf_col_write) begin
      for (int k = 0; k < 4; k++)
        regs[4'(bus.rf_fila + 4'(k))][31-8*bus.rf_columna -: 8] <= bus.rf_data_wr[31-8*k -: 8];
    end
  end
  function automatic logic [31:0] get_col(input logic [1:0] b, input logic [1:0] c);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[31-8*k -: 8] = regs[{b, 2'(k)}][31-8*c -: 8];
    return r;
  endfunction
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic load_col(input logic [1:0] b, input logic [1:0] c, input logic [31:0] v);
    ld_en = 1'b1;
    ld_base = {b, 2'b00};
    ld_c = c;
    ld_val = v;
    @(posedge clk);
    #1;
    ld_en = 1'b0;
  endtask
  // Returns one cycle after done, i.e. in the idle cycle where a back-to-back start is legal.
  task automatic run_op(input logic [1:0] b, input logic iv, output int lat, output int bcnt);
    lat = -1;
    bcnt = 0;
    bus.start = 1'b1;
    bus.blk_sel = b;
    bus.inv = iv;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int n = 1; n <= 20 && lat < 0; n++) begin
      if (bus.busy) bcnt++;
      if (bus.done) lat = n;
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    int lat;
    int bcnt;
    logic [31:0] orig [4];
    logic done_seen;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.blk_sel = 2'd0;
    bus.inv = 1'b0;
    ld_en = 1'b0;
    ld_base = '0;
    ld_c = '0;
    ld_val = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ctrl", 64'({bus.busy, bus.done, bus.rf_col_read, bus.rf_wr_en, bus.rf_col_write}), 64'd0);
    check("reset_addr", 64'({bus.rf_fila, bus.rf_columna}), 64'd0);
    check("reset_data", 64'(bus.rf_data_wr), 64'd0);
    rst_n = 1'b1;
    load_col(2'd0, 2'd0, 32'hDB135345);
    load_col(2'd0, 2'd1, 32'hF20A225C);
    load_col(2'd0, 2'd2, 32'h01010101);
    load_col(2'd0, 2'd3, 32'hC6C6C6C6);
    run_op(2'd0, 1'b0, lat, bcnt);
    check("fwd_latency", 64'(lat), 64'd9);
    check("fwd_busy_cycles", 64'(bcnt), 64'd8);
    check("fwd_c0", 64'(get_col(2'd0, 2'd0)), 64'h8E4DA1BC);
    check("fwd_c1", 64'(get_col(2'd0, 2'd1)), 64'h9FDC589D);
    check("fixed_01", 64'(get_col(2'd0, 2'd2)), 64'h01010101);
    check("fixed_c6", 64'(get_col(2'd0, 2'd3)), 64'hC6C6C6C6);
    run_op(2'd0, 1'b1, lat, bcnt);
    check("b2b_latency", 64'(lat), 64'd9);
    check("inv_c0", 64'(get_col(2'd0, 2'd0)), 64'hDB135345);
    check("inv_c1", 64'(get_col(2'd0, 2'd1)), 64'hF20A225C);
    for (int c = 0; c < 4; c++) begin
      orig[c] = $urandom;
      load_col(2'd2, 2'(c), orig[c]);
    end
    run_op(2'd2, 1'b0, lat, bcnt);
    run_op(2'd2, 1'b1, lat, bcnt);
    for (int c = 0; c < 4; c++) check($sformatf("roundtrip_c%0d", c), 64'(get_col(2'd2, 2'(c))), 64'(orig[c]));
    load_col(2'd1, 2'd0, 32'hDB135345);
    for (int c = 1; c < 4; c++) load_col(2'd1, 2'(c), 32'h0);
    for (int c = 0; c < 4; c++) load_col(2'd3, 2'(c), 32'h01020304 + 32'(c));
    bus.start = 1'b1;
    bus.blk_sel = 2'd1;
    bus.inv = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.blk_sel = 2'd3;
    bus.inv = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.blk_sel = 2'd0;
    done_seen = 1'b0;
    for (int n = 0; n < 20 && !done_seen; n++) begin
      done_seen = bus.done;
      @(posedge clk);
      #1;
    end
    check("ign_done", 64'(done_seen), 64'd1);
    check("ign_no_restart", 64'(bus.busy), 64'd0);
    check("ign_blk1_c0", 64'(get_col(2'd1, 2'd0)), 64'h8E4DA1BC);
    check("ign_blk3_c0", 64'(get_col(2'd3, 2'd0)), 64'h01020304);
    check("ign_blk3_c3", 64'(get_col(2'd3, 2'd3)), 64'h01020307);
    for (int c = 0; c < 4; c++) load_col(2'd0, 2'(c), 32'hD4D4D4D5);
    bus.start = 1'b1;
    bus.blk_sel = 2'd0;
    bus.inv = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    done_seen = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      done_seen = done_seen | bus.done;
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst_ctrl", 64'({bus.busy, bus.done, bus.rf_col_read, bus.rf_wr_en, bus.rf_col_write}), 64'd0);
    check("rst_addr", 64'({bus.rf_fila, bus.rf_columna}), 64'd0);
    check("rst_data", 64'(bus.rf_data_wr), 64'd0);
    rst_n = 1'b1;
    repeat (12) begin
      @(posedge clk);
      #1;
      done_seen = done_seen | bus.done;
    end
    check("rst_no_done", 64'(done_seen), 64'd0);
    check("rst_c0", 64'(get_col(2'd0, 2'd0)), 64'hD5D5D7D6);
    check("rst_c1", 64'(get_col(2'd0, 2'd1)), 64'hD5D5D7D6);
    check("rst_c2", 64'(get_col(2'd0, 2'd2)), 64'hD4D4D4D5);
    check("rst_c3", 64'(get_col(2'd0, 2'd3)), 64'hD4D4D4D5);
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      #1;
      check($sformatf("idle_quiet_%0d", n), 64'({bus.rf_wr_en, bus.rf_col_read, bus.rf_data_wr}), 64'd0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
